// File: rtl/l2_noc_pkg.sv
// Shared NoC2 header layout, capture FSM states and message-type codes.
// Used by the message-capture block and the ILA comparison wrappers.
package l2_noc_pkg;

  // header1 field positions
  localparam int HDR_CHIPID_HI = 63;
  localparam int HDR_CHIPID_LO = 50;
  localparam int HDR_X_HI      = 49;
  localparam int HDR_X_LO      = 42;
  localparam int HDR_Y_HI      = 41;
  localparam int HDR_Y_LO      = 34;
  localparam int HDR_FBITS_HI  = 33;
  localparam int HDR_FBITS_LO  = 30;
  localparam int HDR_LEN_HI    = 29;
  localparam int HDR_LEN_LO    = 22;
  localparam int HDR_TYPE_HI   = 21;
  localparam int HDR_TYPE_LO   = 14;
  localparam int HDR_MSHRID_HI = 13;
  localparam int HDR_MSHRID_LO = 6;
  localparam int HDR_DST_HI    = HDR_CHIPID_HI;
  localparam int HDR_DST_LO    = HDR_Y_LO;

  // header2 address field
  localparam int HDR_ADDR_HI   = 55;
  localparam int HDR_ADDR_LO   = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR2    = 3'd1,
    ST_HDR3    = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_HOLD    = 3'd4
  } cap_state_e;

  localparam logic [7:0] MSG_TYPE_DATA_ACK     = 8'd14;
  localparam logic [7:0] MSG_TYPE_NODATA_ACK   = 8'd15;
  localparam logic [7:0] MSG_TYPE_INV_FWD      = 8'd16;
  localparam logic [7:0] MSG_TYPE_LOAD_MEM_ACK = 8'd24;

endpackage

// File: rtl/noc2_msg_capture.sv
// Deserializes L2 NoC2 packets into one message record held until the
// consumer takes it; at most MAX_DATA payload words are retained.
module noc2_msg_capture
  import l2_noc_pkg::*;
#(
  parameter int FLIT_W   = 64,
  parameter int MAX_DATA = 2,
  parameter int LEN_W    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       noc2_valid,
  input  logic [FLIT_W-1:0]          noc2_data,
  output logic                       noc2_ready,
  output logic                       msg_valid,
  input  logic                       msg_ready,
  output logic [7:0]                 msg_type,
  output logic [7:0]                 msg_mshrid,
  output logic [29:0]                msg_dst,
  output logic [LEN_W-1:0]           msg_len,
  output logic [39:0]                msg_addr,
  output logic [MAX_DATA*FLIT_W-1:0] msg_data,
  output logic                       msg_trunc,
  output logic                       msg_err
);

  localparam int                IDX_W   = $clog2(MAX_DATA + 1);
  localparam logic [IDX_W-1:0]  IDX_SAT = IDX_W'(MAX_DATA);

  cap_state_e       state_q, state_d;
  logic [7:0]       type_q, mshrid_q;
  logic [29:0]      dst_q;
  logic [LEN_W-1:0] len_q, rem_q;
  logic [39:0]      addr_q;
  logic [IDX_W-1:0] idx_q;
  logic             trunc_q, err_q;

  logic             flit_acc;
  logic             last_flit;
  logic [LEN_W-1:0] hdr_len;

  assign flit_acc  = noc2_valid && noc2_ready;
  assign hdr_len   = LEN_W'(noc2_data[HDR_LEN_HI:HDR_LEN_LO]);
  // rem_q still holds the count before this flit is taken off
  assign last_flit = (rem_q == LEN_W'(1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (flit_acc) state_d = (hdr_len == '0) ? ST_HOLD : ST_HDR2;
      ST_HDR2:    if (flit_acc) state_d = last_flit ? ST_HOLD : ST_HDR3;
      ST_HDR3:    if (flit_acc) state_d = last_flit ? ST_HOLD : ST_PAYLOAD;
      ST_PAYLOAD: if (flit_acc && last_flit) state_d = ST_HOLD;
      ST_HOLD:    if (msg_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    noc2_ready = (state_q != ST_HOLD);
    msg_valid  = (state_q == ST_HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      type_q   <= '0;
      mshrid_q <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      rem_q    <= '0;
      addr_q   <= '0;
      idx_q    <= '0;
      trunc_q  <= 1'b0;
      err_q    <= 1'b0;
    end else if (flit_acc) begin
      unique case (state_q)
        ST_IDLE: begin
          type_q   <= noc2_data[HDR_TYPE_HI:HDR_TYPE_LO];
          mshrid_q <= noc2_data[HDR_MSHRID_HI:HDR_MSHRID_LO];
          dst_q    <= noc2_data[HDR_DST_HI:HDR_DST_LO];
          len_q    <= hdr_len;
          rem_q    <= hdr_len;
          addr_q   <= '0;
          idx_q    <= '0;
          trunc_q  <= 1'b0;
          err_q    <= 1'b0;
        end
        ST_HDR2: begin
          addr_q <= noc2_data[HDR_ADDR_HI:HDR_ADDR_LO];
          rem_q  <= rem_q - LEN_W'(1);
          if (last_flit) err_q <= 1'b1;
        end
        ST_HDR3: rem_q <= rem_q - LEN_W'(1);
        ST_PAYLOAD: begin
          rem_q <= rem_q - LEN_W'(1);
          if (idx_q == IDX_SAT) trunc_q <= 1'b1;
          else                  idx_q   <= idx_q + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  // One register per retained payload word; idx_q saturates past the last slot.
  for (genvar gi = 0; gi < MAX_DATA; gi++) begin : g_slot
    logic [FLIT_W-1:0] slot_q;
    always_ff @(posedge clk) begin
      if (rst)
        slot_q <= '0;
      else if (flit_acc && state_q == ST_IDLE)
        slot_q <= '0;
      else if (flit_acc && state_q == ST_PAYLOAD && idx_q == IDX_W'(gi))
        slot_q <= noc2_data;
    end
    assign msg_data[gi*FLIT_W +: FLIT_W] = slot_q;
  end

  assign msg_type   = type_q;
  assign msg_mshrid = mshrid_q;
  assign msg_dst    = dst_q;
  assign msg_len    = len_q;
  assign msg_addr   = addr_q;
  assign msg_trunc  = trunc_q;
  assign msg_err    = err_q;

endmodule

// File: tb/tb_noc2_msg_capture.sv
// Directed bench for noc2_msg_capture: packet-level reference model checked
// every cycle, plus literal expectations for each directed packet.
module tb_noc2_msg_capture;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         noc2_valid = 1'b0;
  logic [63:0]  noc2_data = '0;
  logic         msg_ready = 1'b1;
  logic         noc2_ready, msg_valid, msg_trunc, msg_err;
  logic [7:0]   msg_type, msg_mshrid, msg_len;
  logic [29:0]  msg_dst;
  logic [39:0]  msg_addr;
  logic [127:0] msg_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  noc2_msg_capture #(.FLIT_W(64), .MAX_DATA(2), .LEN_W(8)) dut (
    .clk(clk), .rst(rst),
    .noc2_valid(noc2_valid), .noc2_data(noc2_data), .noc2_ready(noc2_ready),
    .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_type(msg_type), .msg_mshrid(msg_mshrid), .msg_dst(msg_dst),
    .msg_len(msg_len), .msg_addr(msg_addr), .msg_data(msg_data),
    .msg_trunc(msg_trunc), .msg_err(msg_err)
  );

  typedef struct packed {
    logic [7:0]   typ;
    logic [7:0]   mshr;
    logic [29:0]  dst;
    logic [7:0]   len;
    logic [39:0]  addr;
    logic [127:0] data;
    logic         trunc;
    logic         err;
  } rec_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] h1(input logic [29:0] dst, input logic [7:0] len,
                                      input logic [7:0] typ, input logic [7:0] mshr);
    return {dst, 4'h3, len, typ, mshr, 6'h2A};
  endfunction

  function automatic logic [63:0] h2(input logic [39:0] addr);
    return {8'hA5, addr, 16'h5A5A};
  endfunction

  // Message implied by a complete packet, straight from the header/payload rules.
  function automatic rec_t decode(input logic [63:0] f[$]);
    rec_t r;
    logic [63:0] hd;
    int len;
    r = '0;
    hd = f[0];
    len = int'(hd[29:22]);
    r.dst  = hd[63:34];
    r.len  = hd[29:22];
    r.typ  = hd[21:14];
    r.mshr = hd[13:6];
    if (len >= 1) begin
      hd = f[1];
      r.addr = hd[55:16];
    end
    r.err = (len == 1);
    for (int k = 0; k < 2; k++)
      if (3 + k < f.size()) r.data[64*k +: 64] = f[3+k];
    r.trunc = (len > 4);
    return r;
  endfunction

  // Reference model: collects flits while no message is pending.
  logic [63:0] flits[$];
  logic [63:0] mh;
  rec_t        exp_rec = '0;
  bit          exp_busy = 1'b0;
  bit          exp_show = 1'b1;

  always @(negedge clk) begin
    chk("noc2_ready", 128'(noc2_ready), 128'(!exp_busy));
    chk("msg_valid",  128'(msg_valid),  128'(exp_busy));
    if (exp_busy || exp_show) begin
      chk("msg_type",   128'(msg_type),   128'(exp_rec.typ));
      chk("msg_mshrid", 128'(msg_mshrid), 128'(exp_rec.mshr));
      chk("msg_dst",    128'(msg_dst),    128'(exp_rec.dst));
      chk("msg_len",    128'(msg_len),    128'(exp_rec.len));
      chk("msg_addr",   128'(msg_addr),   128'(exp_rec.addr));
      chk("msg_data",   msg_data,         exp_rec.data);
      chk("msg_trunc",  128'(msg_trunc),  128'(exp_rec.trunc));
      chk("msg_err",    128'(msg_err),    128'(exp_rec.err));
    end
    if (rst) begin
      exp_busy = 1'b0;
      exp_show = 1'b1;
      exp_rec  = '0;
      flits.delete();
    end else if (exp_busy) begin
      if (msg_ready) begin
        exp_busy = 1'b0;
        exp_show = 1'b0;
      end
    end else if (noc2_valid) begin
      flits.push_back(noc2_data);
      exp_show = 1'b0;
      mh = flits[0];
      if (flits.size() == 1 + int'(mh[29:22])) begin
        exp_rec  = decode(flits);
        exp_busy = 1'b1;
        flits.delete();
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one flit from posedge+1 and return at posedge+1 after it is taken.
  task automatic send_flit(input logic [63:0] d);
    int t = 0;
    noc2_valid = 1'b1;
    noc2_data  = d;
    @(negedge clk);
    while (!noc2_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("send_timeout", 128'(noc2_ready), 128'(1));
    step();
    noc2_valid = 1'b0;
    noc2_data  = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // Ends at the negedge where msg_valid is seen; wait_cyc counts extra cycles.
  task automatic wait_msg(input string tag, output int wait_cyc);
    int t = 0;
    @(negedge clk);
    while (!msg_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    wait_cyc = t;
    chk({tag, "_msg_valid"}, 128'(msg_valid), 128'(1));
    $display("[%0t] %s: type=%h mshrid=%h dst=%h len=%0d addr=%h data=%h trunc=%b err=%b",
             $time, tag, msg_type, msg_mshrid, msg_dst, msg_len, msg_addr, msg_data,
             msg_trunc, msg_err);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [63:0] hb;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 128'(noc2_ready), 128'(1));
    chk("rst_valid", 128'(msg_valid),  128'(0));
    chk("rst_type",  128'(msg_type),   128'(0));
    chk("rst_addr",  128'(msg_addr),   128'(0));
    chk("rst_data",  msg_data,         128'(0));
    chk("rst_err",   128'(msg_err),    128'(0));
    step();

    // header-only packet
    send_flit(h1(30'h0123_4567, 8'd0, 8'h0F, 8'h12));
    wait_msg("hdr_only", w);
    chk("hdr_only_latency", 128'(w), 128'(0));
    chk("hdr_only_type",  128'(msg_type),   128'(8'h0F));
    chk("hdr_only_mshr",  128'(msg_mshrid), 128'(8'h12));
    chk("hdr_only_dst",   128'(msg_dst),    128'(30'h0123_4567));
    chk("hdr_only_addr",  128'(msg_addr),   128'(0));
    chk("hdr_only_data",  msg_data,         128'(0));
    chk("hdr_only_err",   128'(msg_err),    128'(0));
    step();

    // load-ack packet with two data words
    send_flit(h1(30'h0000_0101, 8'd4, 8'd24, 8'h03));
    send_flit(h2(40'hAB_CDEF_0120));
    send_flit(64'hDEAD_BEEF_0000_0003);
    send_flit(64'h1111_1111_1111_1111);
    send_flit(64'h2222_2222_2222_2222);
    wait_msg("load_ack", w);
    chk("load_ack_latency", 128'(w), 128'(0));
    chk("load_ack_addr",  128'(msg_addr), 128'(40'hAB_CDEF_0120));
    chk("load_ack_data",  msg_data, {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    chk("load_ack_trunc", 128'(msg_trunc), 128'(0));
    chk("load_ack_len",   128'(msg_len),   128'(4));
    step();

    // long payload: len=10, eight data flits, two retained
    send_flit(h1(30'h2AAA_AAAA, 8'd10, 8'd14, 8'h77));
    send_flit(h2(40'h00_0000_1000));
    send_flit(64'h0);
    for (int i = 0; i < 8; i++) send_flit(64'hD000_0000_0000_0000 | 64'(i + 1));
    wait_msg("long", w);
    chk("long_latency", 128'(w), 128'(0));
    chk("long_data",  msg_data, {64'hD000_0000_0000_0002, 64'hD000_0000_0000_0001});
    chk("long_trunc", 128'(msg_trunc), 128'(1));
    chk("long_len",   128'(msg_len),   128'(10));
    step();

    // backpressure: message held while the next header waits
    msg_ready = 1'b0;
    send_flit(h1(30'h0000_0055, 8'd0, 8'h0F, 8'hA1));
    hb = h1(30'h0000_0066, 8'd0, 8'd16, 8'hB2);
    noc2_valid = 1'b1;
    noc2_data  = hb;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 128'(msg_valid),  128'(1));
      chk("bp_ready", 128'(noc2_ready), 128'(0));
      chk("bp_mshr",  128'(msg_mshrid), 128'(8'hA1));
    end
    step();
    msg_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 128'(noc2_ready), 128'(0));
    step();
    @(negedge clk);
    chk("bp_idle_ready", 128'(noc2_ready), 128'(1));
    step();
    noc2_valid = 1'b0;
    noc2_data  = '0;
    wait_msg("bp_next", w);
    chk("bp_next_type", 128'(msg_type),   128'(8'd16));
    chk("bp_next_mshr", 128'(msg_mshrid), 128'(8'hB2));
    step();

    // gapped malformed packet, len=1
    send_flit(h1(30'h0000_0777, 8'd1, 8'h0E, 8'h44));
    idle(2);
    send_flit(h2(40'h12_3400_0040));
    wait_msg("malformed", w);
    chk("malformed_latency", 128'(w), 128'(0));
    chk("malformed_err",  128'(msg_err),  128'(1));
    chk("malformed_addr", 128'(msg_addr), 128'(40'h12_3400_0040));
    chk("malformed_data", msg_data, 128'(0));
    step();

    // reset with 2 of 4 flits received
    send_flit(h1(30'h0000_0999, 8'd4, 8'd24, 8'h09));
    send_flit(h2(40'hFF_0000_0FF0));
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 128'(noc2_ready), 128'(1));
    chk("midrst_valid", 128'(msg_valid),  128'(0));
    chk("midrst_addr",  128'(msg_addr),   128'(0));
    step();
    send_flit(h1(30'h0000_0ABC, 8'd2, 8'd15, 8'h5C));
    send_flit(h2(40'h98_7654_3210));
    send_flit(64'h0123_4567_89AB_CDEF);
    wait_msg("post_rst", w);
    chk("post_rst_latency", 128'(w), 128'(0));
    chk("post_rst_mshr",  128'(msg_mshrid), 128'(8'h5C));
    chk("post_rst_addr",  128'(msg_addr),   128'(40'h98_7654_3210));
    chk("post_rst_data",  msg_data,         128'(0));
    chk("post_rst_err",   128'(msg_err),    128'(0));
    chk("post_rst_trunc", 128'(msg_trunc),  128'(0));
    step();

    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
